vga_pixel_stage: RTL and testbench

- Downstream consumer of the sync generator's H_SYNC/V_SYNC (active-low pulses).
- Recovers horizontal and vertical position from the sync edges and decides the active-video window.
- Issues sequential frame-buffer reads and drives registered RGB444 plus a blanking flag to the DAC pins.
- All logic in the same pixel clock domain as the sync generator.

---
 rtl/vga_pixel_stage.sv | 219 +++++++++++++++++++++
 tb/tb_vga_pixel_stage.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_stage.sv
// vga_pixel_stage: pixel-side consumer of the VGA sync generator.
//
// Recovers line/column position from the active-low H_SYNC/V_SYNC pulses,
// decides the active-video window, issues sequential frame-buffer reads and
// drives registered RGB444 plus BLANK_N to the DAC.
//
// Optional build macro: VGA_TEST_PATTERN_EN
//   When defined, PIX_DATA is ignored, RD_EN is held low and the colour
//   source becomes eight vertical colour bars. Addressing, FRAME_START and
//   the output pipeline timing are unchanged.
module vga_pixel_stage #(
  parameter int H_BP     = 48,   // clocks from H_SYNC rise to first active pixel (>= 1)
  parameter int H_ACTIVE = 640,  // active pixels per line
  parameter int V_BP     = 33,   // lines from V_SYNC rise to first active line
  parameter int V_ACTIVE = 480   // active lines per frame
) (
  input  logic        CLK,
  input  logic        NRST,
  input  logic        H_SYNC,
  input  logic        V_SYNC,
  input  logic [11:0] PIX_DATA,
  output logic        RD_EN,
  output logic [18:0] RD_ADDR,
  output logic [3:0]  RED,
  output logic [3:0]  GREEN,
  output logic [3:0]  BLUE,
  output logic        BLANK_N,
  output logic        FRAME_START
);

  typedef enum logic [1:0] {
    ST_WAIT,  // after reset, waiting for the first H_SYNC rise
    ST_BP,    // horizontal back porch
    ST_ACT,   // active pixel window
    ST_FP     // front porch / sync, waiting for the next H_SYNC rise
  } hstate_e;

  localparam logic [10:0] HBP_LAST   = 11'(H_BP - 1);
  localparam logic [10:0] HACT_LAST  = 11'(H_ACTIVE - 1);
  localparam logic [10:0] VACT_FIRST = 11'(V_BP);
  localparam logic [10:0] VACT_END   = 11'(V_BP + V_ACTIVE);
  localparam logic [9:0]  VCNT_SAT   = '1;

  logic        h_d;
  logic        v_d;
  logic        h_rise;
  logic        v_rise;
  logic [9:0]  vcnt;
  logic        line_active;
  hstate_e     state_q;
  hstate_e     state_d;
  logic [10:0] hcnt_q;
  logic [10:0] hcnt_d;
  logic        rd_int;
  logic        rd_d1;
  logic [11:0] pix_src;

  // Sync history; resets high so an idle-high sync never looks like a rise.
  always_ff @(posedge CLK or negedge NRST) begin
    // NOTE: flops use non-blocking (<=) so every register samples pre-edge values.
    if (!NRST) begin
      h_d <= 1'b1;
      v_d <= 1'b1;
    end else begin
      h_d <= H_SYNC;
      v_d <= V_SYNC;
    end
  end

  assign h_rise = H_SYNC & ~h_d;
  assign v_rise = V_SYNC & ~v_d;

  // Line counter: cleared by a frame start, advanced (saturating) by each line start.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      vcnt <= VCNT_SAT;
    end else if (v_rise) begin
      vcnt <= '0;
    end else if (h_rise && (vcnt != VCNT_SAT)) begin
      vcnt <= vcnt + 10'd1;
    end
  end

  assign line_active = ({1'b0, vcnt} >= VACT_FIRST) && ({1'b0, vcnt} < VACT_END);

  // Horizontal FSM state and column counter.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_q <= ST_WAIT;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
    end
  end

  // Horizontal next-state: porch/active sequencing, any H_SYNC rise restarts the back porch.
  always_comb begin
    // NOTE: defaults assigned first so no path leaves a signal unassigned (no latch).
    state_d = state_q;
    hcnt_d  = hcnt_q;
    unique case (state_q)
      ST_WAIT: begin
        state_d = ST_WAIT;
      end
      ST_BP: begin
        if (hcnt_q == HBP_LAST) begin
          state_d = ST_ACT;
          hcnt_d  = '0;
        end else begin
          hcnt_d = hcnt_q + 11'd1;
        end
      end
      ST_ACT: begin
        if (hcnt_q == HACT_LAST) begin
          state_d = ST_FP;
          hcnt_d  = '0;
        end else begin
          hcnt_d = hcnt_q + 11'd1;
        end
      end
      ST_FP: begin
        state_d = ST_FP;
      end
      default: begin
        state_d = ST_WAIT;
        hcnt_d  = '0;
      end
    endcase
    // A truncated active line is simply abandoned; the address keeps counting from where it stopped.
    if (h_rise) begin
      state_d = ST_BP;
      hcnt_d  = '0;
    end
  end

  // Internal read strobe drives addressing even when the external strobe is suppressed.
  assign rd_int = (state_q == ST_ACT) && line_active;

`ifdef VGA_TEST_PATTERN_EN
  assign RD_EN = 1'b0;
`else
  assign RD_EN = rd_int;
`endif

  // Linear frame-buffer address: post-incremented per read, held after the last pixel.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      RD_ADDR <= '0;
    end else if (v_rise) begin
      RD_ADDR <= '0;
    end else if (rd_int) begin
      RD_ADDR <= RD_ADDR + 19'd1;
    end
  end

  assign FRAME_START = rd_int && (RD_ADDR == '0);

  // Read strobe delayed to the cycle in which the frame buffer returns data.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      rd_d1 <= 1'b0;
    end else begin
      rd_d1 <= rd_int;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [10:0] BAR_LAST = 11'(H_ACTIVE / 8 - 1);

  logic [10:0] bar_px;
  logic [2:0]  bar_idx;
  logic [11:0] pat_d1;
  logic        unused_pix;

  assign unused_pix = ^PIX_DATA;

  // Bar position within the active line; held at zero outside the active window.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (state_q != ST_ACT) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (bar_px == BAR_LAST) begin
      bar_px  <= '0;
      bar_idx <= bar_idx + 3'd1;
    end else begin
      bar_px <= bar_px + 11'd1;
    end
  end

  // Bar colour delayed one cycle so it lines up with rd_d1, like frame-buffer data.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      pat_d1 <= '0;
    end else begin
      pat_d1 <= {{4{bar_idx[2]}}, {4{bar_idx[1]}}, {4{bar_idx[0]}}};
    end
  end

  assign pix_src = pat_d1;
`else
  assign pix_src = PIX_DATA;
`endif

  // Registered DAC outputs: colour only while the pipeline carries an active pixel.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      {RED, GREEN, BLUE} <= '0;
      BLANK_N            <= 1'b0;
    end else begin
      {RED, GREEN, BLUE} <= rd_d1 ? pix_src : 12'h000;
      BLANK_N            <= rd_d1;
    end
  end

endmodule

// File: tb/tb_vga_pixel_stage.sv
// Self-checking bench for vga_pixel_stage.
// u_dut uses the default 640x480 timing; u_small uses a reduced frame so a
// complete frame (all reads, address hold and restart) fits in a short run.
// Build with VGA_TEST_PATTERN_EN defined to check the colour-bar mode.
module tb_vga_pixel_stage;

  localparam int LINE   = 800;
  localparam int HLOW   = 96;
  localparam int HBP    = 48;
  localparam int HACT   = 640;
  localparam int S_HBP  = 4;
  localparam int S_HACT = 16;
  localparam int S_VBP  = 3;
  localparam int S_VACT = 6;
  localparam int S_LINE = 32;
  localparam int S_HLOW = 4;
`ifdef VGA_TEST_PATTERN_EN
  localparam int OBS_LAT = 2;  // activity is observed on BLANK_N, two cycles after the internal read
`else
  localparam int OBS_LAT = 0;  // activity is observed directly on RD_EN
`endif

  typedef struct {
    int          cyc;
    logic [11:0] data;
  } rd_t;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [1:0]  hs = 2'b11;
  logic [1:0]  vs = 2'b11;
  logic [11:0] pix = 12'h000;
  logic [11:0] s_pix = 12'h000;

  logic        a_rd, a_blank, a_fs;
  logic [18:0] a_addr;
  logic [3:0]  a_r, a_g, a_b;
  logic        s_rd, s_blank, s_fs;
  logic [18:0] s_addr;
  logic [3:0]  s_r, s_g, s_b;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  rd_t         sb[$];
  int          exp_addr = 0;
  int          s_exp_addr = 0;
  logic        fb_valid = 1'b0;
  logic [11:0] fb_data = 12'h000;
  logic        prev_obs = 1'b0;
  int          run_start = 0;
  int          run_len = 0;
  int          run_first_addr = 0;
  int          rd_total = 0;
  int          fs_count = 0;
  int          s_total = 0;
  int          pix_idx = 0;
  logic [11:0] px0 = 12'h000;
  logic [11:0] px80 = 12'h000;
  logic [11:0] px560 = 12'h000;

  vga_pixel_stage u_dut (
    .CLK(clk), .NRST(nrst), .H_SYNC(hs[0]), .V_SYNC(vs[0]), .PIX_DATA(pix),
    .RD_EN(a_rd), .RD_ADDR(a_addr), .RED(a_r), .GREEN(a_g), .BLUE(a_b),
    .BLANK_N(a_blank), .FRAME_START(a_fs)
  );

  vga_pixel_stage #(
    .H_BP(S_HBP), .H_ACTIVE(S_HACT), .V_BP(S_VBP), .V_ACTIVE(S_VACT)
  ) u_small (
    .CLK(clk), .NRST(nrst), .H_SYNC(hs[1]), .V_SYNC(vs[1]), .PIX_DATA(s_pix),
    .RD_EN(s_rd), .RD_ADDR(s_addr), .RED(s_r), .GREEN(s_g), .BLUE(s_b),
    .BLANK_N(s_blank), .FRAME_START(s_fs)
  );

  always #5 clk = ~clk;

  // Cycle k is the interval after the k-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Colour bar k = pixel / (HACT/8); R,G,B all-ones per bits k[2],k[1],k[0].
  function automatic logic [11:0] bar(input int idx);
    logic [2:0] k;
    k = 3'(idx / (HACT / 8));
    return {{4{k[2]}}, {4{k[1]}}, {4{k[0]}}};
  endfunction

  // Frame-buffer model: returns RD_ADDR[11:0] one cycle after a read, noise otherwise.
  always @(posedge clk) begin
    #1;
    pix = fb_valid ? fb_data : 12'($urandom);
  end

  // Main-DUT monitor and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    logic obs;
`ifdef VGA_TEST_PATTERN_EN
    obs = a_blank;
    check("rd_en_held_low", a_rd, 1'b0);
    if (a_blank) begin
      check("bar_rgb", {a_r, a_g, a_b}, bar(pix_idx));
      if (pix_idx == 0)   px0   = {a_r, a_g, a_b};
      if (pix_idx == 80)  px80  = {a_r, a_g, a_b};
      if (pix_idx == 560) px560 = {a_r, a_g, a_b};
      pix_idx++;
    end else begin
      check("blank_rgb_zero", {a_r, a_g, a_b}, 12'h000);
      pix_idx = 0;
    end
`else
    logic exp_blank;
    obs = a_rd;
    check("frame_start", a_fs, (a_rd && exp_addr == 0));
    if (a_rd) begin
      check("rd_addr", a_addr, 19'(exp_addr));
      sb.push_back('{cyc: cyc, data: a_addr[11:0]});
      fb_valid = 1'b1;
      fb_data  = a_addr[11:0];
      exp_addr++;
    end else begin
      fb_valid = 1'b0;
    end
    exp_blank = (sb.size() > 0) && (sb[0].cyc + 2 == cyc);
    check("blank_n", a_blank, exp_blank);
    if (exp_blank) begin
      check("rgb_data", {a_r, a_g, a_b}, sb[0].data);
      void'(sb.pop_front());
    end else begin
      check("rgb_zero", {a_r, a_g, a_b}, 12'h000);
    end
`endif
    if (a_fs) fs_count++;
    if (obs) begin
      rd_total++;
      if (!prev_obs) begin
        run_start      = cyc;
        run_len        = 0;
        run_first_addr = int'(a_addr);
      end
      run_len++;
    end
    prev_obs = obs;
  end

  // Reduced-frame monitor: read count and address continuity.
  always @(negedge clk) begin
`ifdef VGA_TEST_PATTERN_EN
    if (s_blank) s_total++;
`else
    if (s_rd) begin
      check("small_rd_addr", s_addr, 19'(s_exp_addr));
      s_exp_addr++;
      s_total++;
    end
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One line: H_SYNC low for 'low' cycles, then high; rise_cyc is the first high cycle.
  task automatic hline(input int sel, input int len, input int low, output int rise_cyc);
    hs[sel] = 1'b0;
    repeat (low) step();
    hs[sel] = 1'b1;
    rise_cyc = cyc;
    repeat (len - low) step();
  endtask

  // Frame start: V_SYNC low pulse; the rise is consumed on the following edge.
  task automatic vpulse(input int sel, input int low);
    vs[sel] = 1'b0;
    repeat (low) step();
    vs[sel] = 1'b1;
    if (sel == 0) exp_addr = 0;
    else s_exp_addr = 0;
    step();
  endtask

  initial begin
    int r;
    int r2;
    int snap;

    // Reset state
    repeat (3) step();
    check("rst_rd_en", a_rd, 1'b0);
    check("rst_rd_addr", a_addr, 19'd0);
    check("rst_rgb", {a_r, a_g, a_b}, 12'h000);
    check("rst_blank_n", a_blank, 1'b0);
    check("rst_frame_start", a_fs, 1'b0);
    check("rst_small_addr", s_addr, 19'd0);
    nrst = 1'b1;

    // Idle syncs: nothing ever happens
    repeat (1000) step();
    check("idle_reads", rd_total, 0);
    check("idle_frame_start", fs_count, 0);

    // Frame start, then 32 blank lines
    vpulse(0, 200);
    for (int i = 0; i < 32; i++) hline(0, LINE, HLOW, r);
    check("vbp_no_reads", rd_total, 0);

    // First active line: activity starts 48 clocks after the edge sampling the H_SYNC rise
    hline(0, LINE, HLOW, r);
    check("line34_start_delay", run_start - (r + 1), HBP + OBS_LAT);
    check("line34_len", run_len, HACT);
    check("line34_addr_end", a_addr, 19'd640);
    check("line34_frame_start", fs_count, 1);
`ifdef VGA_TEST_PATTERN_EN
    check("bar_px0", px0, 12'h000);
    check("bar_px80", px80, 12'h00F);
    check("bar_px560", px560, 12'hFFF);
`else
    check("line34_first_addr", run_first_addr, 0);
`endif

    // Second active line continues the address
    hline(0, LINE, HLOW, r);
    check("line35_len", run_len, HACT);
    check("line35_addr_end", a_addr, 19'd1280);
    check("line35_frame_start", fs_count, 1);

    // Line cut short: early H_SYNC rise lands on the 300th active clock
    hs[0] = 1'b0;
    repeat (HLOW) step();
    hs[0] = 1'b1;
    repeat (252) step();
    hs[0] = 1'b0;
    repeat (HLOW) step();
    hs[0] = 1'b1;
    r2 = cyc;
    repeat (10) step();
    check("trunc_len", run_len, 300);
    check("trunc_rd_en_low", a_rd, 1'b0);
    repeat (694) step();
    check("after_trunc_delay", run_start - (r2 + 1), HBP + OBS_LAT);
    check("after_trunc_len", run_len, HACT);
    check("after_trunc_addr_end", a_addr, 19'd2220);
`ifndef VGA_TEST_PATTERN_EN
    check("after_trunc_first_addr", run_first_addr, 1580);
`endif

    // Reset in the middle of an active line
    hs[0] = 1'b0;
    repeat (HLOW) step();
    hs[0] = 1'b1;
    repeat (200) step();
    check("pre_reset_addr", a_addr, 19'd2371);
    #2;
    nrst = 1'b0;
    sb.delete();
    exp_addr = 0;
    #1;
    check("midrst_rd_en", a_rd, 1'b0);
    check("midrst_rd_addr", a_addr, 19'd0);
    check("midrst_blank_n", a_blank, 1'b0);
    check("midrst_rgb", {a_r, a_g, a_b}, 12'h000);
    check("midrst_frame_start", a_fs, 1'b0);
    step();
    nrst = 1'b1;
    snap = rd_total;
    repeat (400) step();
    hline(0, LINE, HLOW, r);
    hline(0, LINE, HLOW, r);
    check("post_rst_no_reads", rd_total, snap);
    check("post_rst_addr", a_addr, 19'd0);
    vpulse(0, 200);
    hline(0, LINE, HLOW, r);
    check("post_rst_vbp_no_reads", rd_total, snap);

    // Reduced frame: every read happens once, address holds, then restarts
    vpulse(1, 8);
    for (int i = 0; i < S_VBP + S_VACT + 3; i++) hline(1, S_LINE, S_HLOW, r);
    check("small_frame_reads", s_total, S_HACT * S_VACT);
    check("small_frame_addr_hold", s_addr, 19'(S_HACT * S_VACT));
    for (int i = 0; i < 3; i++) hline(1, S_LINE, S_HLOW, r);
    check("small_hold_addr", s_addr, 19'(S_HACT * S_VACT));
    check("small_hold_reads", s_total, S_HACT * S_VACT);
    vpulse(1, 8);
    check("small_restart_addr", s_addr, 19'd0);
    for (int i = 0; i < S_VBP; i++) hline(1, S_LINE, S_HLOW, r);
    check("small_next_reads", s_total, S_HACT * S_VACT + S_HACT);
    check("small_next_addr", s_addr, 19'(S_HACT));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
